// File: rtl/gcd_job_if.sv
// gcd_job_if: operand/result handshakes plus the GCD core control bus.
interface gcd_job_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_gcd;
    logic [CNT_W-1:0] out_cycles;
    logic             core_rst;
    logic             core_start;
    logic [WIDTH-1:0] core_data;
    logic             core_done;
    logic [WIDTH-1:0] core_a;
    modport slave (
        input  in_valid, in_a, in_b, out_ready, core_done, core_a,
        output in_ready, out_valid, out_gcd, out_cycles, core_rst, core_start, core_data
    );
    modport master (
        output in_valid, in_a, in_b, out_ready, core_done, core_a,
        input  in_ready, out_valid, out_gcd, out_cycles, core_rst, core_start, core_data
    );
endinterface

// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: feeds operand pairs to the GCD core and returns result plus cycle count.
module gcd_job_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input logic        clk,
    input logic        rst,
    gcd_job_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_LDA, S_LDB, S_WAIT, S_OUT} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] op_a, op_b, gcd_q;
    logic [CNT_W-1:0] cnt, cnt_inc, cyc_q;
    logic zero_op;
    assign zero_op = bus.in_a == '0 || bus.in_b == '0;
    assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            cnt   <= '0;
            gcd_q <= '0;
            cyc_q <= '0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && bus.in_valid) begin
                op_a <= bus.in_a;
                op_b <= bus.in_b;
                // zero operands never terminate in the core, so resolve them here
                if (zero_op) begin
                    gcd_q <= bus.in_a | bus.in_b;
                    cyc_q <= '0;
                end
            end
            if (state == S_LDB) cnt <= '0;
            else if (state == S_WAIT) cnt <= cnt_inc;
            if (state == S_WAIT && bus.core_done) begin
                gcd_q <= bus.core_a;
                cyc_q <= cnt_inc;
            end
        end
    end
    always_comb begin
        state_n        = state;
        bus.in_ready   = state == S_IDLE;
        bus.out_valid  = state == S_OUT;
        bus.core_start = state == S_START;
        bus.core_rst   = rst || state == S_IDLE || state == S_OUT;
        bus.core_data  = (state == S_START || state == S_LDA) ? op_a : state == S_LDB ? op_b : '0;
        case (state)
            S_IDLE:  if (bus.in_valid) state_n = zero_op ? S_OUT : S_START;
            S_START: state_n = S_LDA;
            S_LDA:   state_n = S_LDB;
            S_LDB:   state_n = S_WAIT;
            S_WAIT:  if (bus.core_done) state_n = S_OUT;
            S_OUT:   if (bus.out_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end
    assign bus.out_gcd    = gcd_q;
    assign bus.out_cycles = cyc_q;
endmodule
